// File: rtl/dmi_arb_pkg.sv
// ============================================================================
// Module      : dmi_arb_pkg
// Description : Shared state, op and response encodings for the DMI request
//               arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RSP  = 2'd3
  } arb_state_e;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  localparam logic [1:0] RESP_OK     = 2'd0;
  localparam logic [1:0] RESP_FAILED = 2'd2;
  localparam logic [1:0] RESP_BUSY   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/dmi_rr_arbiter.sv
// ============================================================================
// Module      : dmi_rr_arbiter
// Description : Round-robin grant: lowest requesting index at or after the
//               pointer wins; the pointer moves past the winner on advance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmi_rr_arbiter #(
  parameter int NumHosts = 2,
  parameter int IdxW     = (NumHosts > 1) ? $clog2(NumHosts) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumHosts-1:0] req_i,
  input  logic                advance_i,
  output logic [NumHosts-1:0] grant_o,
  output logic [IdxW-1:0]     grant_idx_o,
  output logic                grant_any_o
);

  logic [IdxW-1:0] ptr_q;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_any_o = 1'b0;
    for (int i = 0; i < NumHosts; i++) begin
      int j;
      j = int'(ptr_q) + i;
      if (j >= NumHosts) j = j - NumHosts;
      if (!grant_any_o && req_i[j]) begin
        grant_any_o = 1'b1;
        grant_o[j]  = 1'b1;
        grant_idx_o = IdxW'(j);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (advance_i && grant_any_o) begin
      ptr_q <= (grant_idx_o == IdxW'(NumHosts - 1)) ? '0 : grant_idx_o + IdxW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmi_req_arbiter.sv
// ============================================================================
// Module      : dmi_req_arbiter
// Description : Arbitrates several debug hosts onto one DMI port, one
//               transaction outstanding at a time.
//               Optional macro DMI_ARB_TIMEOUT_EN enables the response timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmi_req_arbiter
  import dmi_arb_pkg::*;
#(
  parameter int NumHosts      = 2,
  parameter int AddrWidth     = 7,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 1024
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumHosts-1:0]                 host_req_valid_i,
  output logic [NumHosts-1:0]                 host_req_ready_o,
  input  logic [NumHosts-1:0][AddrWidth-1:0]  host_req_addr_i,
  input  logic [NumHosts-1:0][DataWidth-1:0]  host_req_data_i,
  input  logic [NumHosts-1:0][1:0]            host_req_op_i,
  output logic [NumHosts-1:0]                 host_rsp_valid_o,
  input  logic [NumHosts-1:0]                 host_rsp_ready_i,
  output logic [DataWidth-1:0]                host_rsp_data_o,
  output logic [1:0]                          host_rsp_resp_o,
  output logic                                dm_req_valid_o,
  input  logic                                dm_req_ready_i,
  output logic [AddrWidth-1:0]                dm_req_addr_o,
  output logic [DataWidth-1:0]                dm_req_data_o,
  output logic [1:0]                          dm_req_op_o,
  input  logic                                dm_rsp_valid_i,
  output logic                                dm_rsp_ready_o,
  input  logic [DataWidth-1:0]                dm_rsp_data_i,
  input  logic [1:0]                          dm_rsp_resp_i
);

  localparam int IdxW = (NumHosts > 1) ? $clog2(NumHosts) : 1;

  arb_state_e          state_q, state_nxt;
  logic [IdxW-1:0]     idx_q;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] data_q;
  logic [1:0]          op_q;
  logic [DataWidth-1:0] rsp_data_q;
  logic [1:0]          rsp_resp_q;

  logic [NumHosts-1:0] grant_oh;
  logic [IdxW-1:0]     grant_idx;
  logic                grant_any;
  logic                advance;
  logic                timeout;

  dmi_rr_arbiter #(
    .NumHosts (NumHosts),
    .IdxW     (IdxW)
  ) u_rr (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (host_req_valid_i),
    .advance_i   (advance),
    .grant_o     (grant_oh),
    .grant_idx_o (grant_idx),
    .grant_any_o (grant_any)
  );

`ifdef DMI_ARB_TIMEOUT_EN
  localparam int              CntW    = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TimeoutCycles);

  logic [CntW-1:0] cnt_q;

  // Counter is zeroed while the request is presented, so WAIT always starts at 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (state_q == ST_REQ) begin
      cnt_q <= '0;
    end else if (state_q == ST_WAIT && cnt_q != CntMax) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign timeout = (state_q == ST_WAIT) && !dm_rsp_valid_i && (cnt_q >= CntLast);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt        = state_q;
    advance          = 1'b0;
    host_req_ready_o = '0;
    host_rsp_valid_o = '0;
    dm_req_valid_o   = 1'b0;
    dm_rsp_ready_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        dm_rsp_ready_o = 1'b1;
        if (grant_any) begin
          host_req_ready_o = grant_oh;
          advance          = 1'b1;
          state_nxt        = ST_REQ;
        end
      end
      ST_REQ: begin
        dm_req_valid_o = 1'b1;
        if (dm_req_ready_i) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        dm_rsp_ready_o = 1'b1;
        if (dm_rsp_valid_i || timeout) state_nxt = ST_RSP;
      end
      ST_RSP: begin
        host_rsp_valid_o[idx_q] = 1'b1;
        if (host_rsp_ready_i[idx_q]) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Outputs must read zero for the whole reset interval, not just after the edge.
    if (rst_i) begin
      advance          = 1'b0;
      host_req_ready_o = '0;
      host_rsp_valid_o = '0;
      dm_req_valid_o   = 1'b0;
      dm_rsp_ready_o   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      op_q       <= OP_NOP;
      rsp_data_q <= '0;
      rsp_resp_q <= RESP_OK;
    end else begin
      if (state_q == ST_IDLE && grant_any) begin
        idx_q  <= grant_idx;
        addr_q <= host_req_addr_i[grant_idx];
        data_q <= host_req_data_i[grant_idx];
        op_q   <= host_req_op_i[grant_idx];
      end
      if (state_q == ST_WAIT) begin
        if (dm_rsp_valid_i) begin
          rsp_data_q <= dm_rsp_data_i;
          rsp_resp_q <= dm_rsp_resp_i;
        end else if (timeout) begin
          rsp_data_q <= '0;
          rsp_resp_q <= RESP_FAILED;
        end
      end
    end
  end

  assign dm_req_addr_o   = addr_q;
  assign dm_req_data_o   = data_q;
  assign dm_req_op_o     = op_q;
  assign host_rsp_data_o = rsp_data_q;
  assign host_rsp_resp_o = rsp_resp_q;

endmodule

`default_nettype wire

// File: doc/dmi_req_arbiter.md
DMI_REQ_ARBITER -- requirements
Module: dmi_req_arbiter

Interface
REQ-001 SHALL have parameter NumHosts, default 2, number of debug request sources (1..8).
REQ-002 SHALL have parameter AddrWidth, default 7, DMI address width.
REQ-003 SHALL have parameter DataWidth, default 32, DMI data width.
REQ-004 SHALL have parameter TimeoutCycles, default 1024, response wait limit in cycles (>=2).
REQ-005 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst_i  input  1  asynchronous active-high reset.
REQ-007 SHALL have port host_req_valid_i  input  NumHosts  per-host request valid.
REQ-008 SHALL have port host_req_ready_o  output  NumHosts  per-host request accept.
REQ-009 SHALL have port host_req_addr_i  input  NumHosts x AddrWidth  per-host address.
REQ-010 SHALL have port host_req_data_i  input  NumHosts x DataWidth  per-host write data.
REQ-011 SHALL have port host_req_op_i  input  NumHosts x 2  per-host op (0 nop, 1 read, 2 write).
REQ-012 SHALL have port host_rsp_valid_o  output  NumHosts  per-host response valid.
REQ-013 SHALL have port host_rsp_ready_i  input  NumHosts  per-host response accept.
REQ-014 SHALL have port host_rsp_data_o  output  DataWidth  response data, shared by all hosts.
REQ-015 SHALL have port host_rsp_resp_o  output  2  response code (0 ok, 2 failed, 3 busy), shared.
REQ-016 SHALL have port dm_req_valid_o / dm_req_ready_i  output/input  1/1  downstream request handshake.
REQ-017 SHALL have port dm_req_addr_o / dm_req_data_o / dm_req_op_o  output  AddrWidth/DataWidth/2  downstream request payload.
REQ-018 SHALL have port dm_rsp_valid_i / dm_rsp_ready_o  input/output  1/1  downstream response handshake.
REQ-019 SHALL have port dm_rsp_data_i / dm_rsp_resp_i  input  DataWidth/2  downstream response payload.

Function
REQ-020 SHALL implement FSM IDLE -> REQ -> WAIT -> RSP -> IDLE with at most one transaction outstanding.
REQ-021 IDLE: SHALL grant one valid host round-robin, starting after the last granted index; pulse that host_req_ready_o for one cycle; latch addr/data/op/index; go to REQ.
REQ-022 SHALL give, on simultaneous requests, priority to the lowest index at or after the round-robin pointer; the pointer advances to granted+1 (mod NumHosts).
REQ-023 REQ: SHALL hold dm_req_valid_o=1 with stable latched payload until dm_req_ready_i=1, then go to WAIT; first valid cycle is one cycle after the grant.
REQ-024 WAIT: SHALL drive dm_rsp_ready_o=1; on dm_rsp_valid_i, latch data/resp and go to RSP.
REQ-025 RSP: SHALL assert host_rsp_valid_o only at the latched index and hold data/resp stable until that host_rsp_ready_i=1, then go to IDLE.
REQ-026 SHALL drive dm_rsp_ready_o=1 in IDLE and discard any response arriving there (stale after timeout).
REQ-027 SHALL keep all host_req_ready_o low outside IDLE; a request is never accepted in the cycle a response completes.
REQ-028 Timeout counter SHALL be TimeoutCycles-width-safe ($clog2(TimeoutCycles+1) bits), clear on entry to WAIT, and saturate rather than wrap.

Reset
REQ-029 On rst_i=1, SHALL immediately go to IDLE with pointer 0, counter 0 and all outputs 0 (dm_rsp_ready_o=0), aborting any transaction without a host response.
REQ-030 SHALL hold all outputs 0 while rst_i=1 and resume IDLE behaviour on the first edge after release.

Configuration
REQ-031 With DMI_ARB_TIMEOUT_EN defined: in WAIT, after TimeoutCycles cycles without dm_rsp_valid_i, SHALL go to RSP with data 0 and resp 2 (failed).
REQ-032 Without DMI_ARB_TIMEOUT_EN: SHALL wait in WAIT indefinitely, and no counter logic is present.

Structure
REQ-033 Package dmi_arb_pkg SHALL hold the state enum, op codes (NOP/READ/WRITE) and resp codes (OK/FAILED/BUSY).
REQ-034 Round-robin grant logic SHALL be the sub-module dmi_rr_arbiter (NumHosts, req vector, advance strobe -> one-hot grant + index).

Verification
REQ-035 Single host, NumHosts=2: host0 read addr 0x11, downstream ready immediate, rsp data 0xDEADBEEF resp 0 -> host0 rsp_valid with 0xDEADBEEF/0; host1 rsp_valid stays 0.
REQ-036 Host0 and host1 request in the same cycle from reset -> host0 served first, host1 next; repeated contention alternates 0,1,0,1.
REQ-037 dm_req_ready_i low for 5 cycles -> dm_req_valid_o held 5+ cycles with unchanged addr/data/op.
REQ-038 DMI_ARB_TIMEOUT_EN, TimeoutCycles=16, no response -> host rsp data 0 resp 2 after 16 WAIT cycles; a late response in IDLE is consumed, not forwarded.
REQ-039 rst_i asserted in WAIT -> all outputs 0 within the same cycle; the next request after release completes normally with pointer at 0.
REQ-040 Host1 rsp_ready_i low for 10 cycles -> rsp held stable; no new grant to host0 until it completes.
